// File: rtl/direction_input_ctrl.sv
// direction_input_ctrl
//   Turns four raw board push-buttons into one direction command per press
//   for the game2048 core. The buttons are synchronised, debounced and
//   edge-detected. Simultaneous presses are arbitrated (up > down > left > right).
//   Each command is then held on a valid/ready handshake until the core takes it.
//
//   Optional feature: define DIR_AUTOREPEAT_EN to reissue the held direction.
//   The first reissue comes after REPEAT_DELAY cycles of holding only that
//   button. Later reissues follow every REPEAT_PERIOD cycles after the
//   previous transfer.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  asynchronous reset, active-low
//   btn        in   4  raw buttons, async to clk; [0]=up [1]=down [2]=left [3]=right
//   enable     in   1  high while the game is in its playing state
//   dir_ready  in   1  core can take a move this cycle
//   direction  out  4  one-hot command, 4'b0000 whenever dir_valid=0
//   dir_valid  out  1  direction holds a command not yet taken
//   btn_level  out  4  debounced pressed levels, active-high
//   fsm_state  out  2  current FSM state (0=IDLE 1=PENDING 2=WAIT_RELEASE)
//
// Handshake: a command transfers on every rising clk edge where
// dir_valid && dir_ready. While dir_valid is high, direction does not change
// until a transfer happens or enable drops. A drop of enable withdraws the
// command.
module direction_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic       enable,
   input  logic       dir_ready,
   output logic [3:0] direction,
   output logic       dir_valid,
   output logic [3:0] btn_level,
   output logic [1:0] fsm_state
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DB_SAT  = CW'(DEBOUNCE_CYCLES);
   // Synchroniser reset value is the raw "released" level.
   // This stops the debouncer from seeing a phantom press right after reset.
   localparam logic [3:0] RAW_RELEASED = BTN_ACTIVE_LOW ? 4'hF : 4'h0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_WAIT    = 2'd2
   } state_t;

   logic [3:0]    sync1, sync2, pressed;
   logic [CW-1:0] db_cnt [4];
   logic [3:0]    level_d, press_evt, pick;
   state_t        state, state_n;
   logic [3:0]    dir_q, dir_n;

   // Synchroniser and polarity normalisation (1 = pressed)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= RAW_RELEASED;
         sync2 <= RAW_RELEASED;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   assign pressed = BTN_ACTIVE_LOW ? ~sync2 : sync2;

   // Debounce: the counter runs only while the synced input disagrees with
   // the accepted level. Any agreement (a bounce) restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_level <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (pressed[i] == btn_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_level[i] <= pressed[i];
               db_cnt[i]    <= '0;
            end else if (db_cnt[i] != DB_SAT) begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Press events last exactly one cycle after the btn_level rising edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) level_d <= '0;
      else      level_d <= btn_level;
   end

   assign press_evt = btn_level & ~level_d;

   always_comb begin
      pick = '0;
      if      (press_evt[0]) pick = 4'b0001;
      else if (press_evt[1]) pick = 4'b0010;
      else if (press_evt[2]) pick = 4'b0100;
      else if (press_evt[3]) pick = 4'b1000;
   end

`ifdef DIR_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = $clog2(RMAX + 1);
   // Each threshold is two less than the repeat time.
   // One cycle goes to the WAIT->PENDING step, and one to the transfer itself.
   localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY - 2);
   localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_PERIOD - 2);

   logic [HW-1:0] hold_cnt, hold_n;
   logic          first_q, first_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt <= '0;
         first_q  <= 1'b0;
      end else begin
         hold_cnt <= hold_n;
         first_q  <= first_n;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         dir_q <= '0;
      end else begin
         state <= state_n;
         dir_q <= dir_n;
      end
   end

   always_comb begin
      state_n = state;
      dir_n   = dir_q;
`ifdef DIR_AUTOREPEAT_EN
      hold_n  = hold_cnt;
      first_n = first_q;
`endif
      case (state)
         ST_IDLE: begin
            if (enable && (press_evt != 4'b0000)) begin
               state_n = ST_PENDING;
               dir_n   = pick;
`ifdef DIR_AUTOREPEAT_EN
               first_n = 1'b1;
`endif
            end
         end
         ST_PENDING: begin
            // Either a transfer or a withdrawal ends the command
            if (dir_ready || !enable) begin
               state_n = ST_WAIT;
`ifdef DIR_AUTOREPEAT_EN
               hold_n  = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (btn_level == 4'b0000) begin
               state_n = ST_IDLE;
`ifdef DIR_AUTOREPEAT_EN
               hold_n  = '0;
            end else if (enable && (btn_level == dir_q) && (level_d == btn_level)) begin
               if (hold_cnt == (first_q ? HOLD_FIRST : HOLD_NEXT)) begin
                  state_n = ST_PENDING;
                  first_n = 1'b0;
                  hold_n  = '0;
               end else begin
                  hold_n = hold_cnt + 1'b1;
               end
            end else begin
               hold_n = '0;
`endif
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign dir_valid = (state == ST_PENDING);
   assign direction = dir_valid ? dir_q : 4'b0000;
   assign fsm_state = state;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed bench for direction_input_ctrl.
// It runs with DEBOUNCE_CYCLES=4, active-low buttons, REPEAT_DELAY=20 and REPEAT_PERIOD=8.
module tb_direction_input_ctrl;

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic       enable;
   logic       dir_ready;
   logic [3:0] direction;
   logic       dir_valid;
   logic [3:0] btn_level;
   logic [1:0] fsm_state;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int rises  = 0;
   logic valid_prev = 1'b0;
   int xfer_q[$];

   direction_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .BTN_ACTIVE_LOW (1'b1),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn),
      .enable   (enable),
      .dir_ready(dir_ready),
      .direction(direction),
      .dir_valid(dir_valid),
      .btn_level(btn_level),
      .fsm_state(fsm_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter and transfer log (sampled with pre-edge values)
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (dir_valid && dir_ready) xfer_q.push_back(cyc);
   end

   // count commands offered (rising edges of dir_valid)
   always @(negedge clk) begin
      if (dir_valid && !valid_prev) rises = rises + 1;
      valid_prev = dir_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int xfer_at(input int idx);
      if (idx < xfer_q.size()) return xfer_q[idx];
      return -1000;
   endfunction

   int r0, x0, c0;

   initial begin
      // reset held with up pressed
      rst = 1'b0; btn = 4'hF; enable = 1'b1; dir_ready = 1'b0;
      #2 btn = 4'b1110;
      tick(3);
      check("rst_direction", {4'b0, direction}, 8'h00);
      check("rst_valid",     {7'b0, dir_valid}, 8'h00);
      check("rst_level",     {4'b0, btn_level}, 8'h00);
      check("rst_state",     {6'b0, fsm_state}, 8'h00);
      rst = 1'b1;
      tick(5);
      check("lvl_before_6", {4'b0, btn_level}, 8'h00);
      tick(1);
      check("lvl_after_6",  {4'b0, btn_level}, 8'h01);
      check("valid_at_lvl", {7'b0, dir_valid}, 8'h00);
      tick(1);
      check("first_cmd",    {3'b0, dir_valid, direction}, 8'h11);
      dir_ready = 1'b1;
      tick(1);
      check("first_xfer",   {3'b0, dir_valid, direction}, 8'h00);
      check("wait_state",   {6'b0, fsm_state}, 8'h02);
      dir_ready = 1'b0;
      btn = 4'hF;
      tick(8);
      check("back_idle",    {6'b0, fsm_state}, 8'h00);

      // bounce on left
      r0 = rises;
      for (int i = 0; i < 10; i++) begin
         btn = (i % 2 == 0) ? 4'b1011 : 4'hF;
         tick(2);
      end
      check("bounce_no_cmd", 8'(rises - r0), 8'd0);
      check("bounce_level",  {4'b0, btn_level}, 8'h00);
      btn = 4'b1011;
      tick(7);
      check("bounce_cmd",    {3'b0, dir_valid, direction}, 8'h14);
      dir_ready = 1'b1;
      tick(1);
      check("bounce_xfer",   {7'b0, dir_valid}, 8'h00);
      check("bounce_once",   8'(rises - r0), 8'd1);
      dir_ready = 1'b0;
      btn = 4'hF;
      tick(8);

      // stall on right
      x0 = xfer_q.size();
      btn = 4'b0111;
      tick(7);
      check("stall_cmd", {3'b0, dir_valid, direction}, 8'h18);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("stall_hold", {3'b0, dir_valid, direction}, 8'h18);
      end
      dir_ready = 1'b1;
      tick(1);
      check("stall_after", {3'b0, dir_valid, direction}, 8'h00);
      check("stall_xfers", 8'(xfer_q.size() - x0), 8'd1);
      dir_ready = 1'b0;
      btn = 4'hF;
      tick(8);

      // simultaneous up + right
      r0 = rises;
      btn = 4'b0110;
      tick(6);
      check("simul_level", {4'b0, btn_level}, 8'h09);
      tick(1);
      check("simul_cmd",   {3'b0, dir_valid, direction}, 8'h11);
      dir_ready = 1'b1;
      tick(1);
      check("simul_xfer",  {3'b0, dir_valid, direction}, 8'h00);
      tick(6);
      check("simul_no_right", {3'b0, dir_valid, direction}, 8'h00);
      check("simul_wait",  {6'b0, fsm_state}, 8'h02);
      check("simul_once",  8'(rises - r0), 8'd1);
      dir_ready = 1'b0;
      btn = 4'hF;
      tick(8);

      // gating
      x0 = xfer_q.size();
      enable = 1'b0;
      btn = 4'b1101;
      tick(10);
      check("gate_level", {4'b0, btn_level}, 8'h02);
      check("gate_none",  {7'b0, dir_valid}, 8'h00);
      enable = 1'b1;
      tick(3);
      check("gate_late_en", {7'b0, dir_valid}, 8'h00);
      btn = 4'hF;
      tick(8);
      check("gate_idle", {6'b0, fsm_state}, 8'h00);
      btn = 4'b1101;
      tick(7);
      check("gate_cmd", {3'b0, dir_valid, direction}, 8'h12);
      enable = 1'b0;
      tick(1);
      check("gate_withdraw", {3'b0, dir_valid, direction}, 8'h00);
      check("gate_wstate",   {6'b0, fsm_state}, 8'h02);
      enable = 1'b1;
      tick(3);
      check("gate_no_reissue", {7'b0, dir_valid}, 8'h00);
      check("gate_no_xfer", 8'(xfer_q.size() - x0), 8'd0);
      btn = 4'hF;
      tick(8);

      // asynchronous reset while pending
      btn = 4'b1110;
      tick(7);
      check("arst_pending", {7'b0, dir_valid}, 8'h01);
      r0 = rises;
      #2 rst = 1'b0;
      #1;
      check("arst_valid", {3'b0, dir_valid, direction}, 8'h00);
      check("arst_level", {4'b0, btn_level}, 8'h00);
      check("arst_state", {6'b0, fsm_state}, 8'h00);
      btn = 4'hF;
      tick(1);
      rst = 1'b1;
      tick(12);
      check("arst_no_pulse", 8'(rises - r0), 8'd0);

      // holding up with dir_ready high
      dir_ready = 1'b1;
      x0 = xfer_q.size();
      c0 = cyc;
      btn = 4'b1110;
      tick(60);
      check("hold_first_lat", 8'(xfer_at(x0) - c0), 8'd8);
`ifdef DIR_AUTOREPEAT_EN
      check("repeat_delay",  8'(xfer_at(x0 + 1) - xfer_at(x0)), 8'd20);
      check("repeat_period1", 8'(xfer_at(x0 + 2) - xfer_at(x0 + 1)), 8'd8);
      check("repeat_period2", 8'(xfer_at(x0 + 3) - xfer_at(x0 + 2)), 8'd8);
`else
      check("hold_one_xfer", 8'(xfer_q.size() - x0), 8'd1);
`endif
      btn = 4'hF;
      dir_ready = 1'b0;
      tick(8);
      check("end_idle", {6'b0, fsm_state}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
